// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin arbiter: func codes, FSM
// state encoding, default operand width and a func legality helper.
package alu_pkg;

   localparam int DEFAULT_WORD = 32;

   localparam logic [2:0] FUNC_ADD = 3'b010;
   localparam logic [2:0] FUNC_SUB = 3'b110;
   localparam logic [2:0] FUNC_AND = 3'b000;
   localparam logic [2:0] FUNC_OR  = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // True for the four func codes the ALU implements
   function automatic logic func_legal(input logic [2:0] f);
      return (f == FUNC_ADD) || (f == FUNC_SUB) || (f == FUNC_AND) || (f == FUNC_OR);
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first asserted request at or after
// rr_ptr, wrapping modulo N_REQ. Produces one-hot grant, its index and
// whether any request is present.
module rr_grant #(
   parameter int N_REQ = 2,
   parameter int IDW   = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   grant_idx,
   output logic             any_req
);

   // Scan from rr_ptr upward; the first hit wins and blocks later ones
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!any_req && req[idx]) begin
            any_req    = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ
// requesters. Accept in IDLE, capture ALU result in EXEC, hold the
// tagged response in RESP until consumed.
// Optional build macro ALU_RR_ARBITER_FUNC_CHECK_EN: illegal func codes
// are replaced by ADD and answered with rsp_data=0, rsp_zero=1, rsp_err=1.
module alu_rr_arbiter
   import alu_pkg::*;
#(
   parameter int WORD  = DEFAULT_WORD,
   parameter int N_REQ = 2,
   parameter int IDW   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*WORD-1:0] req_a,
   input  logic [N_REQ*WORD-1:0] req_b,
   input  logic [N_REQ*3-1:0] req_func,
   output logic [WORD-1:0]    alu_a,
   output logic [WORD-1:0]    alu_b,
   output logic [2:0]         alu_func,
   input  logic [WORD-1:0]    alu_out,
   input  logic               alu_zero,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [WORD-1:0]    rsp_data,
   output logic               rsp_zero
`ifdef ALU_RR_ARBITER_FUNC_CHECK_EN
  ,output logic               rsp_err
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic [N_REQ-1:0] grant;
   logic [IDW-1:0]   grant_idx;
   logic             any_req;
   logic [WORD-1:0]  sel_a;
   logic [WORD-1:0]  sel_b;
   logic [2:0]       sel_func;
   logic [2:0]       fwd_func;
   logic [WORD-1:0]  res_data;
   logic             res_zero;

   rr_grant #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_rr_grant (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign sel_a    = req_a[int'(grant_idx)*WORD +: WORD];
   assign sel_b    = req_b[int'(grant_idx)*WORD +: WORD];
   assign sel_func = req_func[int'(grant_idx)*3 +: 3];

`ifdef ALU_RR_ARBITER_FUNC_CHECK_EN
   logic op_bad;

   assign fwd_func = func_legal(sel_func) ? sel_func : FUNC_ADD;
   assign res_data = op_bad ? '0 : alu_out;
   assign res_zero = op_bad ? 1'b1 : alu_zero;

   // Remember whether the accepted op was illegal and report it with the result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_bad  <= 1'b0;
         rsp_err <= 1'b0;
      end else if (state == ST_IDLE && any_req) begin
         op_bad  <= !func_legal(sel_func);
      end else if (state == ST_EXEC) begin
         rsp_err <= op_bad;
      end
   end
`else
   assign fwd_func = sel_func;
   assign res_data = alu_out;
   assign res_zero = alu_zero;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: accept -> one EXEC cycle -> hold RESP until consumed
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (any_req)   state_nxt = ST_EXEC;
         ST_EXEC:                state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: grant only while idle and out of reset; response valid in RESP
   always_comb begin
      req_ready = '0;
      rsp_valid = 1'b0;
      if (!reset && state == ST_IDLE) req_ready = grant;
      if (state == ST_RESP)           rsp_valid = 1'b1;
   end

   // Operand latch on accept, result capture in EXEC, pointer advance on consume
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_func <= FUNC_ADD;
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         rr_ptr   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: if (any_req) begin
               alu_a    <= sel_a;
               alu_b    <= sel_b;
               alu_func <= fwd_func;
               rsp_id   <= grant_idx;
            end
            ST_EXEC: begin
               rsp_data <= res_data;
               rsp_zero <= res_zero;
            end
            ST_RESP: if (rsp_ready) begin
               rr_ptr <= (rsp_id == IDW'(N_REQ-1)) ? '0 : rsp_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: supplies the external ALU, runs a
// transaction-level reference model checked every cycle, and applies
// directed vectors with hand-computed expectations.
module tb_alu_rr_arbiter;

   localparam int WORD  = 32;
   localparam int N_REQ = 2;
   localparam int IDW   = 1;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*WORD-1:0]   req_a;
   logic [N_REQ*WORD-1:0]   req_b;
   logic [N_REQ*3-1:0]      req_func;
   logic [WORD-1:0]         alu_a, alu_b, alu_out, rsp_data;
   logic [2:0]              alu_func;
   logic                    alu_zero, rsp_valid, rsp_ready, rsp_zero;
   logic [IDW-1:0]          rsp_id;
`ifdef ALU_RR_ARBITER_FUNC_CHECK_EN
   logic                    rsp_err;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_rr_arbiter #(.WORD(WORD), .N_REQ(N_REQ), .IDW(IDW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_func  (req_func),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_func  (alu_func),
      .alu_out   (alu_out),
      .alu_zero  (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero)
`ifdef ALU_RR_ARBITER_FUNC_CHECK_EN
     ,.rsp_err   (rsp_err)
`endif
   );

   // Behaviour of the external ALU; undefined codes give a^b so pass-through is visible
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
      case (f)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_out  = alu_ref(alu_a, alu_b, alu_func);
   assign alu_zero = (alu_out == '0);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase counts progress through one transaction: 0 waiting for a
   // request, 1 result being computed, 2 response offered.
   int          m_phase;
   int          m_ptr;
   int          m_id;
   logic [31:0] m_a, m_b, m_data;
   logic [2:0]  m_f;
   logic        m_zero, m_err, m_bad;

   function automatic int pick(input logic [N_REQ-1:0] v, input int p);
      for (int k = 0; k < N_REQ; k++)
         if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
      return -1;
   endfunction

   function automatic logic illegal(input logic [2:0] f);
`ifdef ALU_RR_ARBITER_FUNC_CHECK_EN
      return !(f inside {3'b010, 3'b110, 3'b000, 3'b001});
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase <= 0;
         m_ptr   <= 0;
         m_id    <= 0;
         m_a     <= '0;
         m_b     <= '0;
         m_f     <= 3'b010;
         m_data  <= '0;
         m_zero  <= 1'b0;
         m_err   <= 1'b0;
         m_bad   <= 1'b0;
      end else if (m_phase == 2) begin
         if (rsp_ready) begin
            m_phase <= 0;
            m_ptr   <= (m_id + 1) % N_REQ;
         end
      end else if (m_phase == 1) begin
         m_data  <= m_bad ? 32'd0 : alu_ref(m_a, m_b, m_f);
         m_zero  <= m_bad ? 1'b1 : (alu_ref(m_a, m_b, m_f) == 32'd0);
         m_err   <= m_bad;
         m_phase <= 2;
      end else if (pick(req_valid, m_ptr) >= 0) begin
         m_id    <= pick(req_valid, m_ptr);
         m_a     <= req_a[pick(req_valid, m_ptr)*WORD +: WORD];
         m_b     <= req_b[pick(req_valid, m_ptr)*WORD +: WORD];
         m_bad   <= illegal(req_func[pick(req_valid, m_ptr)*3 +: 3]);
         m_f     <= illegal(req_func[pick(req_valid, m_ptr)*3 +: 3]) ? 3'b010
                    : req_func[pick(req_valid, m_ptr)*3 +: 3];
         m_phase <= 1;
      end
   end

   function automatic logic [N_REQ-1:0] exp_ready(input logic rst, input int ph,
                                                  input logic [N_REQ-1:0] v, input int p);
      if (rst || ph != 0 || pick(v, p) < 0) return '0;
      return N_REQ'(1) << pick(v, p);
   endfunction

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready(reset, m_phase, req_valid, m_ptr)));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      chk("alu_a",     64'(alu_a),     64'(m_a));
      chk("alu_b",     64'(alu_b),     64'(m_b));
      chk("alu_func",  64'(alu_func),  64'(m_f));
      chk("rsp_id",    64'(rsp_id),    64'(m_id));
      chk("rsp_data",  64'(rsp_data),  64'(m_data));
      chk("rsp_zero",  64'(rsp_zero),  64'(m_zero));
`ifdef ALU_RR_ARBITER_FUNC_CHECK_EN
      chk("rsp_err",   64'(rsp_err),   64'(m_err));
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for rsp_valid on a falling edge; n = falling edges consumed
   task automatic wait_rsp(output int n);
      n = 0;
      while (n < 12) begin
         @(negedge clk);
         n++;
         if (rsp_valid === 1'b1) return;
      end
      n_vec++;
      n_bad++;
      $display("FAIL wait_rsp: no rsp_valid within %0d cycles at %0t", n, $time);
   endtask

   int n;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_func  = '0;
      #12;
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset req_ready", 64'(req_ready), 64'd0);
      chk("reset alu_func",  64'(alu_func),  64'h2);
      chk("reset rsp_data",  64'(rsp_data),  64'd0);
      step();
      reset = 1'b0;

      // single op: 5 + 3 from requester 0
      rsp_ready = 1'b1;
      req_valid = 2'b01;
      req_a[0 +: 32] = 32'd5;  req_b[0 +: 32] = 32'd3;  req_func[0 +: 3] = 3'b010;
      @(negedge clk);
      chk("single req_ready", 64'(req_ready), 64'h1);
      step();
      req_valid = 2'b00;
      wait_rsp(n);
      chk("single latency", 64'(n), 64'd2);
      chk("single data", 64'(rsp_data), 64'd8);
      chk("single zero", 64'(rsp_zero), 64'd0);
      chk("single id",   64'(rsp_id),   64'd0);
      step();

      // zero flag: 7 - 7 from requester 1
      req_valid = 2'b10;
      req_a[32 +: 32] = 32'd7;  req_b[32 +: 32] = 32'd7;  req_func[3 +: 3] = 3'b110;
      @(negedge clk);
      chk("zero req_ready", 64'(req_ready), 64'h2);
      step();
      req_valid = 2'b00;
      wait_rsp(n);
      chk("zero data", 64'(rsp_data), 64'd0);
      chk("zero flag", 64'(rsp_zero), 64'd1);
      chk("zero id",   64'(rsp_id),   64'd1);
      step();

      // fairness: both requesters held valid
      req_a[0 +: 32]  = 32'hF0F0; req_b[0 +: 32]  = 32'hFF00; req_func[0 +: 3] = 3'b000;
      req_a[32 +: 32] = 32'd1;    req_b[32 +: 32] = 32'd2;    req_func[3 +: 3] = 3'b001;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_rsp(n);
         chk("fair spacing", 64'(n), 64'd3);
         chk("fair id",      64'(rsp_id), 64'(k % 2));
         chk("fair data",    64'(rsp_data), (k % 2 == 1) ? 64'h3 : 64'hF000);
      end
      step();

      // backpressure: 10 + 20 held while requester 1 waits
      rsp_ready = 1'b0;
      req_a[0 +: 32]  = 32'd10;  req_b[0 +: 32] = 32'd20; req_func[0 +: 3] = 3'b010;
      req_a[32 +: 32] = 32'd100; req_b[32 +: 32] = 32'd1; req_func[3 +: 3] = 3'b110;
      req_valid = 2'b01;
      step();
      req_valid = 2'b10;
      wait_rsp(n);
      for (int k = 0; k < 5; k++) begin
         chk("bp rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp data",      64'(rsp_data),  64'd30);
         chk("bp req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      step();
      rsp_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp next grant", 64'(req_ready), 64'h2);
      step();
      req_valid = 2'b00;
      wait_rsp(n);
      chk("bp2 data", 64'(rsp_data), 64'd99);
      chk("bp2 id",   64'(rsp_id),   64'd1);
      step();

`ifdef ALU_RR_ARBITER_FUNC_CHECK_EN
      // illegal func 111 is answered with an error, then a legal ADD
      req_a[0 +: 32] = 32'd1; req_b[0 +: 32] = 32'd1; req_func[0 +: 3] = 3'b111;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      @(negedge clk);
      chk("bad alu_func", 64'(alu_func), 64'h2);
      wait_rsp(n);
      chk("bad err",  64'(rsp_err),  64'd1);
      chk("bad data", 64'(rsp_data), 64'd0);
      chk("bad zero", 64'(rsp_zero), 64'd1);
      step();
      req_func[0 +: 3] = 3'b010;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      wait_rsp(n);
      chk("good err",  64'(rsp_err),  64'd0);
      chk("good data", 64'(rsp_data), 64'd2);
      step();
`else
      // undefined func 111 reaches the ALU unchanged: 6 ^ 3 = 5
      req_a[0 +: 32] = 32'd6; req_b[0 +: 32] = 32'd3; req_func[0 +: 3] = 3'b111;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      @(negedge clk);
      chk("pass alu_func", 64'(alu_func), 64'h7);
      wait_rsp(n);
      chk("pass data", 64'(rsp_data), 64'd5);
      step();
`endif

      // reset while a response is pending
      rsp_ready = 1'b0;
      req_a[32 +: 32] = 32'd9; req_b[32 +: 32] = 32'd4; req_func[3 +: 3] = 3'b110;
      req_valid = 2'b10;
      step();
      req_valid = 2'b00;
      wait_rsp(n);
      chk("pre-reset data", 64'(rsp_data), 64'd5);
      #2;
      reset = 1'b1;
      #1;
      chk("async rsp_valid", 64'(rsp_valid), 64'd0);
      chk("async alu_func",  64'(alu_func),  64'h2);
      chk("async rsp_data",  64'(rsp_data),  64'd0);
      chk("async rsp_id",    64'(rsp_id),    64'd0);
      chk("async alu_a",     64'(alu_a),     64'd0);
      step();
      reset     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      @(negedge clk);
      chk("ptr after reset", 64'(req_ready), 64'h1);
      step();
      req_valid = 2'b00;
      wait_rsp(n);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d vectors, want completion", n_vec);
      $fatal(1);
   end

endmodule
